int_cycle_sequencer: RTL

Owns the cycle counter and instruction register that feed the 6502 instruction decoder's `cycle[2:0]` and `inst[7:0]` inputs. Consumes the decoder's `icyc`, `rcyc` and `scyc` strobes to step the cycle counter. Latches and prioritises reset, NMI and IRQ requests and presents them to the decoder. At every instruction boundary it substitutes the interrupt pseudo-opcode 8'h00 when an interrupt is pending.

---
 rtl/int_cycle_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/int_cycle_sequencer.sv
// Cycle counter, instruction register and interrupt arbitration feeding the 6502 decoder.
// Optional build macro INT_SYNC_EN adds two-flop synchronizers on the irq and nmi inputs.
module int_cycle_sequencer #(
    parameter logic [7:0] INT_OPCODE = 8'h00,
    parameter logic [2:0] LAST_CYCLE = 3'd7
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       irq,
    input  logic       nmi,
    input  logic       irq_dis,
    input  logic [7:0] opcode_in,
    input  logic       icyc,
    input  logic       rcyc,
    input  logic       scyc,
    output logic [2:0] cycle,
    output logic [7:0] inst,
    output logic       pend_reset,
    output logic       pend_nmi,
    output logic       pend_irq,
    output logic       sync,
    output logic [1:0] int_ack
);

    typedef enum logic [1:0] {
        ACK_NONE  = 2'b00,
        ACK_RESET = 2'b01,
        ACK_NMI   = 2'b10,
        ACK_IRQ   = 2'b11
    } ack_e;

    logic       irq_s;
    logic       nmi_s;

`ifdef INT_SYNC_EN
    logic [1:0] irq_sync_q;
    logic [1:0] nmi_sync_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            irq_sync_q <= 2'b00;
            nmi_sync_q <= 2'b00;
        end else begin
            irq_sync_q <= {irq_sync_q[0], irq};
            nmi_sync_q <= {nmi_sync_q[0], nmi};
        end
    end

    assign irq_s = irq_sync_q[1];
    assign nmi_s = nmi_sync_q[1];
`else
    assign irq_s = irq;
    assign nmi_s = nmi;
`endif

    logic [2:0] cycle_q,      cycle_d;
    logic [7:0] inst_q,       inst_d;
    logic       pend_reset_q, pend_reset_d;
    logic       pend_nmi_q,   pend_nmi_d;
    logic       pend_irq_q,   pend_irq_d;
    logic       nmi_q;
    ack_e       int_ack_q,    int_ack_d;
    logic       nmi_edge;
    logic       any_pend;

    assign nmi_edge = nmi_s & ~nmi_q;
    assign any_pend = pend_reset_q | pend_nmi_q | pend_irq_q;

    always_comb begin
        // NOTE: every next-state variable gets a default first so no path leaves it unassigned (no latch).
        cycle_d      = cycle_q;
        inst_d       = inst_q;
        pend_reset_d = pend_reset_q;
        pend_nmi_d   = pend_nmi_q;
        pend_irq_d   = irq_s & ~irq_dis;
        int_ack_d    = ACK_NONE;

        if (rcyc) begin
            cycle_d = 3'd0;
        end else if (scyc) begin
            cycle_d = 3'd2;
        end else if (icyc) begin
            cycle_d = (cycle_q == LAST_CYCLE) ? 3'd0 : cycle_q + 3'd1;
        end

        if (rcyc) begin
            inst_d = any_pend ? INT_OPCODE : opcode_in;
        end

        // Only the highest-priority pending source is acknowledged; irq clears itself by resampling.
        if (scyc) begin
            if (pend_reset_q) begin
                pend_reset_d = 1'b0;
                int_ack_d    = ACK_RESET;
            end else if (pend_nmi_q) begin
                pend_nmi_d   = 1'b0;
                int_ack_d    = ACK_NMI;
            end else if (pend_irq_q) begin
                int_ack_d    = ACK_IRQ;
            end
        end

        // A fresh edge arriving in the service cycle must not be lost.
        if (nmi_edge) begin
            pend_nmi_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cycle_q      <= 3'd0;
            inst_q       <= INT_OPCODE;
            pend_reset_q <= 1'b1;
            pend_nmi_q   <= 1'b0;
            pend_irq_q   <= 1'b0;
            nmi_q        <= 1'b0;
            int_ack_q    <= ACK_NONE;
        end else begin
            cycle_q      <= cycle_d;
            inst_q       <= inst_d;
            pend_reset_q <= pend_reset_d;
            pend_nmi_q   <= pend_nmi_d;
            pend_irq_q   <= pend_irq_d;
            nmi_q        <= nmi_s;
            int_ack_q    <= int_ack_d;
        end
    end

    assign cycle      = cycle_q;
    assign inst       = inst_q;
    assign pend_reset = pend_reset_q;
    assign pend_nmi   = pend_nmi_q;
    assign pend_irq   = pend_irq_q;
    assign int_ack    = int_ack_q;
    assign sync       = (cycle_q == 3'd0);

endmodule
